// File: rtl/dp_ram_pipe.sv
// Dual-port RAM (one read port, one bit-masked write port) with a 1- or 2-cycle read pipeline.
// Define DP_RAM_PIPE_WRITE_BYPASS_EN to let a same-cycle, same-address write show up in the read result.
module dp_ram_pipe #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2**ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  CEA,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic                  CEB,
  input  logic [ADDR_WIDTH-1:0] AB,
  input  logic [DATA_WIDTH-1:0] DB,
  input  logic [DATA_WIDTH-1:0] BWB,
  output logic [DATA_WIDTH-1:0] QA,
  output logic                  QA_VALID,
  output logic                  ADDR_ERR
);

  localparam int unsigned DEPTH_U = DEPTH;

  // QA_VALID is a one-cycle strobe with no backpressure; QA holds its value between strobes.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_merged;

  assign rd_in_range = (32'(AA) < DEPTH_U);
  assign wr_in_range = (32'(AB) < DEPTH_U);

  // Array has no reset; writes are simply blocked while rst is high.
  always_ff @(posedge CLK or posedge rst) begin
    if (!rst && CEB && wr_in_range) begin
      mem_q[AB] <= (mem_q[AB] & ~BWB) | (DB & BWB);
    end
  end

  always_comb begin
    s1_valid_d = CEA;
    s1_data_d  = s1_data_q;
    if (CEA) begin
      s1_data_d = rd_in_range ? mem_q[AA] : '0;
    end
    err_d = err_q | (CEA & ~rd_in_range) | (CEB & ~wr_in_range);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      err_q      <= err_d;
    end
  end

`ifdef DP_RAM_PIPE_WRITE_BYPASS_EN
  // The colliding write's data and mask travel with the read and are merged on output.
  logic                  s1_col_q, s1_col_d;
  logic [DATA_WIDTH-1:0] s1_db_q, s1_db_d;
  logic [DATA_WIDTH-1:0] s1_bwb_q, s1_bwb_d;

  always_comb begin
    s1_col_d = s1_col_q;
    s1_db_d  = s1_db_q;
    s1_bwb_d = s1_bwb_q;
    if (CEA) begin
      s1_col_d = CEB && (AA == AB) && rd_in_range;
      s1_db_d  = DB;
      s1_bwb_d = BWB;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      s1_col_q <= 1'b0;
      s1_db_q  <= '0;
      s1_bwb_q <= '0;
    end else begin
      s1_col_q <= s1_col_d;
      s1_db_q  <= s1_db_d;
      s1_bwb_q <= s1_bwb_d;
    end
  end

  assign rd_merged = s1_col_q ? ((s1_data_q & ~s1_bwb_q) | (s1_db_q & s1_bwb_q)) : s1_data_q;
`else
  assign rd_merged = s1_data_q;
`endif

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign QA       = rd_merged;
      assign QA_VALID = s1_valid_q;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] qa_q, qa_d;
      logic                  qa_valid_q, qa_valid_d;

      always_comb begin
        qa_valid_d = s1_valid_q;
        qa_d       = qa_q;
        if (s1_valid_q) begin
          qa_d = rd_merged;
        end
      end

      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          qa_q       <= '0;
          qa_valid_q <= 1'b0;
        end else begin
          qa_q       <= qa_d;
          qa_valid_q <= qa_valid_d;
        end
      end

      assign QA       = qa_q;
      assign QA_VALID = qa_valid_q;
    end
  endgenerate

  assign ADDR_ERR = err_q;

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Bench for dp_ram_pipe: latency-1 and latency-2 instances (DEPTH=48) share one stimulus stream
// and are checked against an array-plus-delay-queue model of the RAM.
module tb_dp_ram_pipe;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int DEP = 48;

`ifdef DP_RAM_PIPE_WRITE_BYPASS_EN
  localparam logic [DW-1:0] COL_EXP = 32'h1111AAAA;
`else
  localparam logic [DW-1:0] COL_EXP = 32'h11111111;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cea, ceb;
  logic [AW-1:0] aa, ab;
  logic [DW-1:0] db, bwb;
  logic [DW-1:0] qa1, qa2;
  logic          qv1, qv2, er1, er2;

  logic [DW-1:0] qa [2];
  logic          qv [2];
  logic          er [2];
  assign qa[0] = qa1;
  assign qa[1] = qa2;
  assign qv[0] = qv1;
  assign qv[1] = qv2;
  assign er[0] = er1;
  assign er[1] = er2;

  dp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .READ_LATENCY(1)) u_l1 (
    .CLK(clk), .rst(rst), .CEA(cea), .AA(aa), .CEB(ceb), .AB(ab), .DB(db), .BWB(bwb),
    .QA(qa1), .QA_VALID(qv1), .ADDR_ERR(er1)
  );

  dp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .READ_LATENCY(2)) u_l2 (
    .CLK(clk), .rst(rst), .CEA(cea), .AA(aa), .CEB(ceb), .AB(ab), .DB(db), .BWB(bwb),
    .QA(qa2), .QA_VALID(qv2), .ADDR_ERR(er2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  int            due_q0[$], due_q1[$];
  logic [DW-1:0] held [2];
  logic [DW-1:0] eq [2];
  logic          ev [2];
  logic          err_m;
  int            cyc;
  int            n_pass, n_total;

  task automatic model_clear();
    exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
    held[0] = '0; held[1] = '0;
    eq[0] = '0; eq[1] = '0;
    ev[0] = 1'b0; ev[1] = 1'b0;
    err_m = 1'b0;
  endtask

  // driver: apply one cycle of inputs, advance the model, leave expected outputs in ev/eq/err_m
  task automatic step(input logic c_a, input logic [AW-1:0] a_a, input logic c_b,
                      input logic [AW-1:0] a_b, input logic [DW-1:0] d_b, input logic [DW-1:0] m_b);
    logic [DW-1:0] r;
    cea = c_a; aa = a_a; ceb = c_b; ab = a_b; db = d_b; bwb = m_b;
    @(posedge clk);
    cyc++;
    if (c_a) begin
      r = (int'(a_a) < DEP) ? mdl[a_a] : '0;
`ifdef DP_RAM_PIPE_WRITE_BYPASS_EN
      if (c_b && (a_b == a_a) && (int'(a_a) < DEP)) r = (r & ~m_b) | (d_b & m_b);
`endif
      exp_q0.push_back(r); due_q0.push_back(cyc);
      exp_q1.push_back(r); due_q1.push_back(cyc + 1);
      if (int'(a_a) >= DEP) err_m = 1'b1;
    end
    if (c_b) begin
      if (int'(a_b) < DEP) mdl[a_b] = (mdl[a_b] & ~m_b) | (d_b & m_b);
      else err_m = 1'b1;
    end
    #1;
    ev[0] = 1'b0; ev[1] = 1'b0;
    if (due_q0.size() > 0 && due_q0[0] == cyc) begin
      ev[0] = 1'b1; held[0] = exp_q0.pop_front(); void'(due_q0.pop_front());
    end
    if (due_q1.size() > 0 && due_q1[0] == cyc) begin
      ev[1] = 1'b1; held[1] = exp_q1.pop_front(); void'(due_q1.pop_front());
    end
    eq[0] = held[0]; eq[1] = held[1];
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1; cea = 1'b0; ceb = 1'b0; aa = '0; ab = '0; db = '0; bwb = '0;
    cyc = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (qv[k] !== 1'b0 || qa[k] !== '0 || er[k] !== 1'b0)
        $display("FAIL reset lat%0d: valid=%b qa=%h err=%b, required 0/0/0", k + 1, qv[k], qa[k], er[k]);
      else n_pass++;
    end
    #4 rst = 1'b0;
  endtask

  task automatic test_init();
    for (int i = 0; i < DEP; i++) begin
      step(1'b0, '0, 1'b1, AW'(i), $urandom, '1);
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (qv[k] !== ev[k] || qa[k] !== eq[k] || er[k] !== err_m)
          $display("FAIL init lat%0d: valid=%b qa=%h err=%b, required %b/%h/%b", k + 1, qv[k], qa[k], er[k], ev[k], eq[k], err_m);
        else n_pass++;
      end
    end
  endtask

  task automatic test_basic();
    step(1'b0, '0, 1'b1, 6'd5, 32'hDEADBEEF, '1);
    step(1'b1, 6'd5, 1'b0, '0, '0, '0);
    n_total++;
    if (qv[0] !== 1'b1 || qa[0] !== 32'hDEADBEEF || qv[1] !== 1'b0)
      $display("FAIL basic_lat1: valid1=%b qa1=%h valid2=%b, required 1/deadbeef/0", qv[0], qa[0], qv[1]);
    else n_pass++;
    idle();
    n_total++;
    if (qv[1] !== 1'b1 || qa[1] !== 32'hDEADBEEF || qv[0] !== 1'b0 || qa[0] !== 32'hDEADBEEF)
      $display("FAIL basic_lat2: valid2=%b qa2=%h valid1=%b qa1=%h, required 1/deadbeef/0/deadbeef", qv[1], qa[1], qv[0], qa[0]);
    else n_pass++;
    idle();
    n_total++;
    if (qv[0] !== 1'b0 || qv[1] !== 1'b0 || qa[1] !== 32'hDEADBEEF)
      $display("FAIL basic_after: valid1=%b valid2=%b qa2=%h, required 0/0/deadbeef", qv[0], qv[1], qa[1]);
    else n_pass++;
  endtask

  task automatic test_collision();
    step(1'b0, '0, 1'b1, 6'd3, 32'h11111111, '1);
    step(1'b1, 6'd3, 1'b1, 6'd3, 32'hAAAAAAAA, 32'h0000FFFF);
    n_total++;
    if (qv[0] !== 1'b1 || qa[0] !== COL_EXP)
      $display("FAIL collision_lat1: valid=%b qa=%h, required 1/%h", qv[0], qa[0], COL_EXP);
    else n_pass++;
    step(1'b1, 6'd3, 1'b1, 6'd3, 32'h55555555, '0);
    n_total++;
    if (qv[1] !== 1'b1 || qa[1] !== COL_EXP || qa[0] !== 32'h1111AAAA)
      $display("FAIL collision_lat2: valid=%b qa2=%h qa1=%h, required 1/%h/1111aaaa", qv[1], qa[1], qa[0], COL_EXP);
    else n_pass++;
    idle();
    n_total++;
    if (qv[1] !== 1'b1 || qa[1] !== 32'h1111AAAA)
      $display("FAIL collision_reread: valid=%b qa=%h, required 1/1111aaaa", qv[1], qa[1]);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [DW-1:0] m2;
    m2 = mdl[2];
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1'b1, AW'(i), 1'b0, '0, '0, '0);
      else idle();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (qv[k] !== ev[k] || qa[k] !== eq[k] || er[k] !== err_m)
          $display("FAIL stream lat%0d cyc%0d: valid=%b qa=%h err=%b, required %b/%h/%b", k + 1, i, qv[k], qa[k], er[k], ev[k], eq[k], err_m);
        else n_pass++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (qv[k] !== 1'b0 || qa[k] !== m2)
        $display("FAIL stream_hold lat%0d: valid=%b qa=%h, required 0/%h", k + 1, qv[k], qa[k], m2);
      else n_pass++;
    end
  endtask

  task automatic test_late_write();
    logic [DW-1:0] old7;
    old7 = mdl[7];
    step(1'b1, 6'd7, 1'b0, '0, '0, '0);
    step(1'b0, '0, 1'b1, 6'd7, 32'h5, '1);
    n_total++;
    if (qv[1] !== 1'b1 || qa[1] !== old7)
      $display("FAIL late_write_old: valid=%b qa=%h, required 1/%h", qv[1], qa[1], old7);
    else n_pass++;
    step(1'b1, 6'd7, 1'b0, '0, '0, '0);
    n_total++;
    if (qv[0] !== 1'b1 || qa[0] !== 32'h5)
      $display("FAIL late_write_new_lat1: valid=%b qa=%h, required 1/00000005", qv[0], qa[0]);
    else n_pass++;
    idle();
    n_total++;
    if (qv[1] !== 1'b1 || qa[1] !== 32'h5)
      $display("FAIL late_write_new_lat2: valid=%b qa=%h, required 1/00000005", qv[1], qa[1]);
    else n_pass++;
  endtask

  task automatic test_random(input int n, input int amax);
    logic [AW-1:0] ra, wa;
    for (int i = 0; i < n; i++) begin
      ra = AW'($urandom_range(0, amax));
      wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, amax));
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom,
           ($urandom_range(0, 4) == 0) ? '0 : $urandom);
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (qv[k] !== ev[k] || qa[k] !== eq[k] || er[k] !== err_m)
          $display("FAIL random lat%0d cyc%0d: valid=%b qa=%h err=%b, required %b/%h/%b", k + 1, cyc, qv[k], qa[k], er[k], ev[k], eq[k], err_m);
        else n_pass++;
      end
    end
  endtask

  task automatic test_oor();
    logic [DW-1:0] snap [DEP];
    for (int i = 0; i < DEP; i++) snap[i] = mdl[i];
    step(1'b0, '0, 1'b1, 6'd50, 32'hCAFEF00D, '1);
    n_total++;
    if (er[0] !== 1'b1 || er[1] !== 1'b1)
      $display("FAIL oor_write_err: err1=%b err2=%b, required 1/1", er[0], er[1]);
    else n_pass++;
    step(1'b1, 6'd50, 1'b0, '0, '0, '0);
    n_total++;
    if (qv[0] !== 1'b1 || qa[0] !== '0)
      $display("FAIL oor_read_lat1: valid=%b qa=%h, required 1/00000000", qv[0], qa[0]);
    else n_pass++;
    idle();
    n_total++;
    if (qv[1] !== 1'b1 || qa[1] !== '0)
      $display("FAIL oor_read_lat2: valid=%b qa=%h, required 1/00000000", qv[1], qa[1]);
    else n_pass++;
    // array untouched: read back every word through the latency-1 instance
    for (int i = 0; i < DEP; i++) begin
      step(1'b1, AW'(i), 1'b0, '0, '0, '0);
      n_total++;
      if (qv[0] !== 1'b1 || qa[0] !== snap[i] || er[0] !== 1'b1 || er[1] !== 1'b1)
        $display("FAIL oor_array addr%0d: valid=%b qa=%h err=%b/%b, required 1/%h/1/1", i, qv[0], qa[0], er[0], er[1], snap[i]);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] m9;
    m9 = mdl[9];
    step(1'b1, 6'd9, 1'b0, '0, '0, '0);
    cea = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (qv[k] !== 1'b0 || qa[k] !== '0 || er[k] !== 1'b0)
        $display("FAIL reset_mid lat%0d: valid=%b qa=%h err=%b, required 0/0/0", k + 1, qv[k], qa[k], er[k]);
      else n_pass++;
    end
    model_clear();
    cea = 1'b1; aa = 6'd9; ceb = 1'b1; ab = 6'd9; db = ~m9; bwb = '1;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (qv[k] !== 1'b0 || qa[k] !== '0 || er[k] !== 1'b0)
        $display("FAIL reset_held lat%0d: valid=%b qa=%h err=%b, required 0/0/0", k + 1, qv[k], qa[k], er[k]);
      else n_pass++;
    end
    cea = 1'b0; ceb = 1'b0;
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) step(1'b1, 6'd9, 1'b0, '0, '0, '0);
      else idle();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (qv[k] !== ev[k] || qa[k] !== eq[k] || er[k] !== err_m)
          $display("FAIL reset_release lat%0d cyc%0d: valid=%b qa=%h err=%b, required %b/%h/%b", k + 1, i, qv[k], qa[k], er[k], ev[k], eq[k], err_m);
        else n_pass++;
      end
    end
    n_total++;
    if (qa[1] !== m9)
      $display("FAIL reset_array_kept: qa=%h, required %h", qa[1], m9);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_init();
    test_basic();
    test_collision();
    test_stream();
    test_late_write();
    test_random(300, DEP - 1);
    test_oor();
    test_reset_mid();
    test_random(300, 63);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dp_ram_pipe.md
DP_RAM_PIPE -- requirements
Module: dp_ram_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: width of the read and write addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH: number of words, 2..2**ADDR_WIDTH, not required to be a power of two.
REQ-004 SHALL have parameter READ_LATENCY, default 1: number of cycles from a read request to its data, legal values 1 or 2.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port CEA, input, 1 bit: read request.
REQ-008 SHALL have port AA, input, ADDR_WIDTH bits: read address.
REQ-009 SHALL have port CEB, input, 1 bit: write request.
REQ-010 SHALL have port AB, input, ADDR_WIDTH bits: write address.
REQ-011 SHALL have port DB, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port BWB, input, DATA_WIDTH bits: bit write enable; 1 = write that bit.
REQ-013 SHALL have port QA, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port QA_VALID, output, 1 bit: 1-cycle pulse marking new data on QA.
REQ-015 SHALL have port ADDR_ERR, output, 1 bit: sticky flag for an out-of-range access.

Function
REQ-016 SHALL hold a DEPTH x DATA_WIDTH array internally; a write with CEB=1 and AB<DEPTH SHALL update only the bits where BWB=1, at the rising edge of that cycle.
REQ-017 SHALL start the read of word AA at the edge of a cycle with CEA=1; the array value sampled SHALL be the content before any same-edge write.
REQ-018 SHALL drive the read data on QA, with QA_VALID=1, exactly READ_LATENCY cycles after the request cycle; back-to-back reads SHALL give one result per cycle, in order.
REQ-019 SHALL hold QA at its last value when QA_VALID=0, until the next read result arrives; idle cycles SHALL NOT change QA.
REQ-020 SHALL detect a collision when CEA=1, CEB=1, AA==AB and AA<DEPTH in the same cycle.
REQ-021 SHALL, on a collision, capture DB and BWB with the read and carry them down the read pipeline.
REQ-022 SHALL, on a collision, return (array_data & ~BWB) | (DB & BWB); the read sees its own-cycle write.
REQ-023 SHALL NOT merge writes issued after the read's request cycle into that read's result, for either READ_LATENCY.
REQ-024 SHALL, for a read with AA>=DEPTH, return all-zero data with QA_VALID still pulsed, and set ADDR_ERR.
REQ-025 SHALL, for a write with AB>=DEPTH, leave the array unchanged, set ADDR_ERR, and never report a collision.
REQ-026 SHALL keep ADDR_ERR at 1 until reset.
REQ-027 SHALL keep CEB=1 with BWB=0 a no-op for the array; a collision in that case SHALL return the unmodified array data.

Reset
REQ-028 SHALL, while rst=1, force QA=0, QA_VALID=0 and ADDR_ERR=0, and clear all read-pipeline valid bits and collision state, independent of CLK.
REQ-029 SHALL NOT reset array contents; reads of never-written words return undefined data.
REQ-030 SHALL discard any read in flight when rst asserts; no QA_VALID pulse SHALL appear for it after release.
REQ-031 SHALL ignore CEA and CEB while rst=1; normal operation SHALL resume on the first rising edge with rst=0.

Configuration
REQ-032 SHALL provide the macro DP_RAM_PIPE_WRITE_BYPASS_EN; when defined, collision handling per REQ-020..REQ-022 SHALL be compiled in.
REQ-033 SHALL, when DP_RAM_PIPE_WRITE_BYPASS_EN is undefined, remove the collision logic; a colliding read SHALL return pre-write (old) data, and the write SHALL still complete.

Verification
REQ-034 SHALL cover basic read/write: write 0xDEADBEEF to addr 5 with BWB all-ones, then read addr 5 -> QA=0xDEADBEEF with QA_VALID exactly READ_LATENCY cycles later, for both latencies.
REQ-035 SHALL cover a masked collision: mem[3]=0x11111111; same cycle read 3 and write 3 with DB=0xAAAAAAAA, BWB=0x0000FFFF -> with the macro QA=0x1111AAAA, without it QA=0x11111111; a later read of 3 returns 0x1111AAAA in both builds.
REQ-036 SHALL cover hold and streaming: reads of addresses 0,1,2 on consecutive cycles, then idle 4 cycles -> three in-order QA_VALID pulses, then QA stays equal to mem[2] with QA_VALID=0.
REQ-037 SHALL cover late-write isolation: READ_LATENCY=2, read 7 at cycle t, write 7 with 0x5 at cycle t+1 -> QA shows the old mem[7]; a read at t+2 returns 0x5.
REQ-038 SHALL cover out-of-range access: DEPTH=48, write addr 50 then read addr 50 -> array unchanged, QA=0, QA_VALID pulsed, ADDR_ERR=1 held until rst.
REQ-039 SHALL cover reset mid-operation: assert rst one cycle after a read request with READ_LATENCY=2 -> QA=0 and QA_VALID=0 immediately; no pulse after release.
